// File: rtl/vape_mc_pkg.sv
// Shared types, default widths and the packed-bound slice helper for the
// multi-channel execution-proof monitor.
package vape_mc_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_CNT_W  = 8;
  localparam int unsigned MAX_BUS_W  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  // Returns channel ch's bound in the low bits; callers size-cast to ADDR_W.
  function automatic logic [MAX_BUS_W-1:0] bound_slice(
    input logic [MAX_BUS_W-1:0] bus,
    input int unsigned          ch,
    input int unsigned          addr_w
  );
    return bus >> (ch * addr_w);
  endfunction

endpackage

// File: rtl/vape_exec_ch.sv
// One execution-proof channel: IDLE/RUN/DONE FSM with bounds latched on entry.
// Optional saturating abort counter under VAPE_ABORT_CNT_EN.
module vape_exec_ch
  import vape_mc_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] er_min,
  input  logic [ADDR_W-1:0] er_max,
  input  logic              dmem_wen,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              viol,
`ifdef VAPE_ABORT_CNT_EN
  output logic [CNT_W-1:0]  abort_cnt,
`endif
  output logic              exec
);

  ch_state_e         state_q, state_d;
  logic [ADDR_W-1:0] min_q, min_d;
  logic [ADDR_W-1:0] max_q, max_d;

  logic cfg_ok, in_er, wr_er, cfg_chg, abort;

  assign cfg_ok  = (er_min <= er_max);
  assign in_er   = (pc >= er_min) && (pc <= er_max);
  assign wr_er   = dmem_wen && (dmem_addr >= er_min) && (dmem_addr <= er_max);
  assign cfg_chg = (er_min != min_q) || (er_max != max_q);
  assign abort   = viol || !cfg_ok || wr_er || ((state_q != ST_IDLE) && cfg_chg);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    case (state_q)
      ST_IDLE: begin
        if (!abort && (pc == er_min)) begin
          state_d = ST_RUN;
          min_d   = er_min;
          max_d   = er_max;
        end
      end
      ST_RUN: begin
        if (abort)               state_d = ST_IDLE;
        else if (pc == er_max)   state_d = ST_DONE;
        else if (!in_er)         state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pc == er_min) begin
          state_d = ST_RUN;
          min_d   = er_min;
          max_d   = er_max;
        end
      end
      // Encoding 2'd3 is unreachable; fall back to IDLE if it ever appears.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  assign exec = (state_q == ST_RUN) || (state_q == ST_DONE);

`ifdef VAPE_ABORT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dropped;

  assign dropped = ((state_q == ST_RUN) || (state_q == ST_DONE)) && (state_d == ST_IDLE);

  always_comb begin
    cnt_d = cnt_q;
    if (dropped && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign abort_cnt = cnt_q;
`endif

endmodule

// File: rtl/vape_exec_monitor_mc.sv
// Top of the multi-channel execution-proof monitor: NUM_CH independent channels.
// Optional per-channel abort counters are built when VAPE_ABORT_CNT_EN is defined.
module vape_exec_monitor_mc
  import vape_mc_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [NUM_CH*ADDR_W-1:0] er_min,
  input  logic [NUM_CH*ADDR_W-1:0] er_max,
  input  logic                     dmem_wen,
  input  logic [ADDR_W-1:0]        dmem_addr,
  input  logic                     viol,
`ifdef VAPE_ABORT_CNT_EN
  output logic [NUM_CH*CNT_W-1:0]  abort_cnt,
`endif
  output logic [NUM_CH-1:0]        exec,
  output logic                     exec_any
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ADDR_W-1:0] ch_min, ch_max;

    assign ch_min = ADDR_W'(bound_slice(MAX_BUS_W'(er_min), i, ADDR_W));
    assign ch_max = ADDR_W'(bound_slice(MAX_BUS_W'(er_max), i, ADDR_W));

    vape_exec_ch #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .pc        (pc),
      .er_min    (ch_min),
      .er_max    (ch_max),
      .dmem_wen  (dmem_wen),
      .dmem_addr (dmem_addr),
      .viol      (viol),
`ifdef VAPE_ABORT_CNT_EN
      .abort_cnt (abort_cnt[i*CNT_W +: CNT_W]),
`endif
      .exec      (exec[i])
    );
  end

  assign exec_any = |exec;

endmodule

// File: doc/vape_exec_monitor_mc.md
Name: vape_exec_monitor_mc

Overview:
- Multi-channel successor to the single-region execution-proof FSM.
- Tracks NUM_CH independent executable regions (ER), each bounded by [er_min, er_max].
- Per channel, asserts exec only while an execution started at the region's first instruction has not been violated, and keeps it asserted after a clean exit at er_max.
- Sits beside the core and memory backbone; the exec flags feed the attestation/report logic.

Parameters:
- NUM_CH, 4: number of independent ER channels.
- ADDR_W, 16: width of pc, region bounds and data address.
- CNT_W, 8: abort-counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces every channel to IDLE.
- pc  in  ADDR_W  current program counter.
- er_min  in  NUM_CH*ADDR_W  packed region start; channel i at bits [i*ADDR_W +: ADDR_W].
- er_max  in  NUM_CH*ADDR_W  packed region end (inclusive), same packing.
- dmem_wen  in  1  data-memory write strobe.
- dmem_addr  in  ADDR_W  data-memory write address.
- viol  in  1  external violation (e.g. irq/DMA/debug); aborts all channels.
- exec  out  NUM_CH  per-channel execution-proof flag.
- exec_any  out  1  OR of exec.
- abort_cnt  out  NUM_CH*CNT_W  per-channel abort count; present only with VAPE_ABORT_CNT_EN.

Behaviour:
- Per-channel FSM with states IDLE, RUN, DONE.
- exec[i] is registered: 1 in RUN/DONE, 0 in IDLE.
- Reset value: all channels IDLE, exec=0, exec_any=0, abort_cnt=0.
- Definitions, per channel i:
  - cfg_ok = er_min <= er_max (unsigned compare).
  - in_er = er_min <= pc <= er_max.
  - wr_er = dmem_wen && dmem_addr in [er_min, er_max].
  - cfg_chg = er_min/er_max differ from the copy registered on entry to RUN.
- Abort condition: viol || !cfg_ok || wr_er || (state != IDLE && cfg_chg).
- Priority, highest first: reset, abort condition, pc rules.
- Transitions:
  - IDLE -> RUN when pc == er_min, cfg_ok and no abort condition. Latch the bounds. exec=1 from the next cycle (1-cycle latency).
  - RUN -> IDLE on abort, or when !in_er (illegal exit from anywhere but er_max).
  - RUN -> DONE when pc == er_max.
  - RUN stays RUN otherwise, including pc == er_min (inner loop).
  - DONE -> IDLE on abort.
  - DONE -> RUN when pc == er_min (re-execution; re-latch the bounds; exec stays 1).
  - DONE stays DONE otherwise; exec holds 1 regardless of pc.
- Single-instruction region (er_min == er_max): IDLE -> RUN on entry, then RUN -> DONE the next cycle if pc still equals er_max; otherwise the !in_er rule applies.
- Simultaneous entry and abort: abort wins; channel stays IDLE.
- Channels are fully independent; overlapping regions are legal.
- An asynchronous reset mid-RUN drops exec immediately.
- exec_any is the combinational OR of the registered exec vector.

Optional Feature:
- Macro: VAPE_ABORT_CNT_EN.
- Defined:
  - abort_cnt[i] increments on each RUN/DONE -> IDLE transition.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Undefined: the abort_cnt port and the counters are absent; all other behaviour is identical.

Decomposition:
- Package vape_mc_pkg:
  - State enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2); encoding 2'd3 is illegal and recovers to IDLE.
  - Default widths.
  - Slice helper for packed bounds.
- Sub-module vape_exec_ch: one channel's FSM, latched bounds and optional counter.
- The top instantiates NUM_CH copies via generate and forms exec_any.

Test Plan:
- Ch0 ER=0xE000..0xE0FE; pc 0xE000, 0xE002, …, 0xE0FE, then 0x4000 -> exec[0]=1 from the cycle after 0xE000, stays 1 after exit; state DONE.
- Ch0 in RUN; pc jumps 0xE010 -> 0x4000 -> exec[0]=0 next cycle. With VAPE_ABORT_CNT_EN, abort_cnt[0]=1.
- Ch1 ER=0xF000..0xF0FE in RUN; dmem_wen=1, dmem_addr=0xF020 -> exec[1]=0; ch0 unaffected.
- viol=1 in the same cycle as pc=0xE000 from IDLE -> exec[0] stays 0. viol pulse while ch0 is DONE -> exec[0]=0.
- er_max[0] changed from 0xE0FE to 0xE1FE while RUN -> exec[0]=0 next cycle. er_min=0xE100 > er_max=0xE000 -> channel never leaves IDLE.
- Assert reset asynchronously mid-RUN -> exec=0 before the next clk edge. 300 aborts with CNT_W=8 -> abort_cnt saturates at 255.
